// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, BIT_NUM data bits LSB first, 1 stop bit, CLK_CYCLES clocks per bit.
// Optional parity (extra bit between data and stop) is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int unsigned CLK_CYCLES = 868,
    parameter int unsigned BIT_NUM    = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_rx_data,
    output logic [BIT_NUM-1:0] o_data,
    output logic               o_valid,
    output logic               o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic               o_parity_err,
`endif
    output logic               o_busy
);

    localparam int IDX_W = $clog2(BIT_NUM);
    localparam logic [15:0]      HALF_LAST = 16'(CLK_CYCLES / 2 - 1);
    localparam logic [15:0]      BIT_LAST  = 16'(CLK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BIT_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             r_state, w_state;
    logic               r_sync1, r_rx_s, r_rx_prev;
    logic [15:0]        r_cnt, w_cnt;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic [BIT_NUM-1:0] r_shift, w_shift;
    logic [BIT_NUM-1:0] r_data, w_data;
    logic               r_valid, w_valid;
    logic               r_frame_err, w_frame_err;
    logic               r_par, w_par;
    logic               r_parity_err, w_parity_err;
    logic               w_par_bad;

    // Synchroniser flops idle high so reset never looks like a start edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= i_rx_data;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_idx        <= w_idx;
            r_shift      <= w_shift;
            r_data       <= w_data;
            r_valid      <= w_valid;
            r_frame_err  <= w_frame_err;
            r_par        <= w_par;
            r_parity_err <= w_parity_err;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = r_par != ((^r_shift) ^ PARITY_ODD);
`else
    assign w_par_bad = 1'b0;
`endif

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt + 16'd1;
        w_idx        = r_idx;
        w_shift      = r_shift;
        w_data       = r_data;
        w_valid      = 1'b0;
        w_frame_err  = 1'b0;
        w_par        = r_par;
        w_parity_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (r_rx_prev && !r_rx_s) w_state = S_START;
            end
            S_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt   = '0;
                    w_idx   = '0;
                    w_state = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt   = '0;
                    w_shift = {r_rx_s, r_shift[BIT_NUM-1:1]};
                    if (r_idx == IDX_LAST) begin
                        w_idx   = '0;
`ifdef UART_RX_PARITY_EN
                        w_state = S_PARITY;
`else
                        w_state = S_STOP;
`endif
                    end else begin
                        w_idx = r_idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt   = '0;
                    w_par   = r_rx_s;
                    w_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid stop bit lets a back-to-back start edge be caught
                if (r_cnt == BIT_LAST) begin
                    w_cnt   = '0;
                    w_state = S_IDLE;
                    if (!r_rx_s) begin
                        w_frame_err = 1'b1;
                    end else if (w_par_bad) begin
                        w_parity_err = 1'b1;
                    end else begin
                        w_valid = 1'b1;
                        w_data  = r_shift;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a frame driver pushes expected pulses, a monitor pops them.
// Build with UART_RX_PARITY_EN defined to also exercise the even-parity variant.
module tb_uart_rx;

    localparam int CLK = 16;
    localparam int NB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif
    // Spec latency is F + CLK/2 + (NB+1)*CLK + 1, and F is two edges after the line changes
    localparam int LAT = 2 + CLK / 2 + (NB + 1) * CLK + 1 + (HAS_PAR ? CLK : 0);

    localparam int K_VALID = 1;
    localparam int K_FERR  = 2;
    localparam int K_PERR  = 4;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } exp_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rxLine = 1'b1;
    logic [7:0] oData;
    logic       oValid, oFrameErr, oBusy, perrSig;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    exp_t       q[$];
    logic [7:0] lastGood = 8'h00;
    int         monHeld  = 0;

    uart_rx #(
        .CLK_CYCLES(CLK),
        .BIT_NUM   (NB)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rxLine),
        .o_data      (oData),
        .o_valid     (oValid),
        .o_frame_err (oFrameErr),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(perrSig),
`endif
        .o_busy      (oBusy)
    );

`ifndef UART_RX_PARITY_EN
    assign perrSig = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic goodPar(input logic [7:0] d);
        return ^d;
    endfunction

    // Drives one full frame starting at a negedge; expectation is pushed before the line moves
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input logic parBit);
        exp_t e;
        if (!stopBit)
            e.kind = K_FERR;
        else if (HAS_PAR && (parBit != goodPar(d)))
            e.kind = K_PERR;
        else
            e.kind = K_VALID;
        e.data = (e.kind == K_VALID) ? int'(d) : int'(lastGood);
        e.cyc  = cyc + LAT;
        if (e.kind == K_VALID) lastGood = d;
        q.push_back(e);
        rxLine = 1'b0;
        repeat (CLK) @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            rxLine = d[i];
            if (i == 4) begin
                repeat (CLK / 2) @(negedge clk);
                checkOutput("busy_mid_frame", int'(oBusy), 1);
                repeat (CLK - CLK / 2) @(negedge clk);
            end else begin
                repeat (CLK) @(negedge clk);
            end
        end
        if (HAS_PAR) begin
            rxLine = parBit;
            repeat (CLK) @(negedge clk);
        end
        rxLine = stopBit;
        repeat (CLK) @(negedge clk);
    endtask

    task automatic drainQueue();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
        checkOutput("queue_drained", q.size(), 0);
    endtask

    // Monitor: pops one expectation per output pulse, otherwise checks o_data holds
    always @(negedge clk) begin
        if (!rst_n) begin
            monHeld = 0;
        end else if (oValid || oFrameErr || perrSig) begin
            checkOutput("pulse_exclusive", int'(oValid) + int'(oFrameErr) + int'(perrSig), 1);
            if (q.size() == 0) begin
                checkOutput("unexpected_pulse", int'({perrSig, oFrameErr, oValid}), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                checkOutput("pulse_kind", int'({perrSig, oFrameErr, oValid}), e.kind);
                checkOutput("pulse_cycle", cyc, e.cyc);
                checkOutput("pulse_data", int'(oData), e.data);
                if (e.kind == K_VALID) monHeld = e.data;
            end
        end else begin
            checkOutput("data_stable", int'(oData), monHeld);
            if (q.size() != 0 && cyc > q[0].cyc) begin
                checkOutput("missed_pulse", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       sb;
        logic [7:0] abortWord;

        repeat (3) @(negedge clk);
        checkOutput("reset_data", int'(oData), 0);
        checkOutput("reset_valid", int'(oValid), 0);
        checkOutput("reset_ferr", int'(oFrameErr), 0);
        checkOutput("reset_busy", int'(oBusy), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] single frame 0xA5");
        applyStimulus(8'hA5, 1'b1, goodPar(8'hA5));
        repeat (20) @(negedge clk);

        $display("[TB] short glitch");
        rxLine = 1'b0;
        repeat (4) @(negedge clk);
        rxLine = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("glitch_idle", int'(oBusy), 0);

        $display("[TB] framing error then break hold");
        applyStimulus(8'h3C, 1'b0, goodPar(8'h3C));
        repeat (20) @(negedge clk);
        checkOutput("no_start_in_break", int'(oBusy), 0);
        repeat (20) @(negedge clk);
        rxLine = 1'b1;
        repeat (CLK) @(negedge clk);
        applyStimulus(8'h81, 1'b1, goodPar(8'h81));

        $display("[TB] back-to-back frames");
        applyStimulus(8'h00, 1'b1, goodPar(8'h00));
        applyStimulus(8'hFF, 1'b1, goodPar(8'hFF));
        applyStimulus(8'h55, 1'b1, goodPar(8'h55));
        repeat (10) @(negedge clk);
        drainQueue();

        $display("[TB] reset during frame");
        abortWord = 8'hC3;
        rxLine = 1'b0;
        repeat (CLK) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxLine = abortWord[i];
            repeat (CLK) @(negedge clk);
        end
        rxLine = abortWord[3];
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        lastGood = 8'h00;
        @(negedge clk);
        checkOutput("midreset_data", int'(oData), 0);
        checkOutput("midreset_valid", int'(oValid), 0);
        checkOutput("midreset_ferr", int'(oFrameErr), 0);
        checkOutput("midreset_busy", int'(oBusy), 0);
        rxLine = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("post_reset_idle", int'(oBusy), 0);
        applyStimulus(8'h12, 1'b1, goodPar(8'h12));
        repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity frames");
        applyStimulus(8'h07, 1'b1, 1'b1);
        applyStimulus(8'h07, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
`endif

        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 9) != 0);
            applyStimulus(d, sb, goodPar(d) ^ ($urandom_range(0, 6) == 0));
            if (!sb) begin
                rxLine = 1'b1;
                repeat ($urandom_range(2, 20)) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
        end

        drainQueue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver that is the downstream partner of the team's UART transmitter. It consumes the asynchronous serial line driven by the transmitter, which uses 1 start bit, BIT_NUM data bits (LSB first) and 1 stop bit. It recovers each data word and presents it in parallel with a one-cycle valid strobe. Bit timing comes from the same CLK_CYCLES-per-bit parameter the transmitter uses, so a TX/RX pair built with identical parameters interoperates directly.

Parameters:
CLK_CYCLES, 868, i_clk cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535
BIT_NUM, 8, data bits per frame; legal range 5..16

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_rx_data  input  1  serial line, idle high, asynchronous to i_clk
o_data  output  BIT_NUM  last correctly received word, LSB = first bit on line
o_valid  output  1  one-cycle pulse: o_data updated this cycle
o_frame_err  output  1  one-cycle pulse: stop bit sampled low, frame discarded
o_busy  output  1  high while state != IDLE

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: state IDLE; o_data 0; o_valid 0; o_frame_err 0; o_busy 0; bit counter 0; bit index 0; synchroniser flops and previous-sample flop all 1.
- Input synchroniser: 2-flop synchroniser on i_rx_data. The FSM sees only the second flop ("rx_s"). A third flop ("rx_prev") holds the previous rx_s for edge detection.
- Cycle counter: 16-bit. Bit index: enough bits to count 0..BIT_NUM-1.
- IDLE:
  - Enter START when rx_prev=1 and rx_s=0 (falling edge); clear the counter.
  - A line held low continuously (break) never triggers a new start.
- START:
  - Count to CLK_CYCLES/2-1, using integer division.
  - At that count, if rx_s=0: go to DATA, clear the counter and the bit index.
  - If rx_s=1 at that count: treat as a glitch, return to IDLE with no output pulse.
- DATA:
  - At count CLK_CYCLES-1, sample rx_s into the shift register. Shift right, so the first bit ends in bit 0 after BIT_NUM shifts.
  - Clear the counter and increment the bit index.
  - After sampling bit index BIT_NUM-1, go to STOP.
- STOP: at count CLK_CYCLES-1 (mid stop bit), sample rx_s.
  - If rx_s=1: o_data <= shift register and o_valid=1 on the next cycle.
  - If rx_s=0: o_frame_err=1 on the next cycle and o_data is held unchanged.
  - In both cases return to IDLE on the same edge as the pulse.
- o_valid and o_frame_err:
  - Registered outputs, high for exactly one cycle, never high together.
  - No handshake: the consumer must capture o_data on o_valid. o_data stays stable until the next valid frame.
- Latency: with F = the i_clk edge at which the first rx_s=0 is registered, o_valid rises at F + CLK_CYCLES/2 + (BIT_NUM+1)*CLK_CYCLES + 1 cycles.
- Back-to-back frames: returning to IDLE at mid stop bit allows the next start edge to be detected with no gap cycles required.
- Reset mid-frame: the FSM aborts immediately, no pulse is generated, and partial data is lost. After release, the receiver waits for a fresh falling edge.

Optional Feature:
UART_RX_PARITY_EN: when defined, adds a parameter PARITY_ODD (default 0 = even) and an output o_parity_err (1 bit, reset 0).
- Behaviour with the macro defined:
  - A PARITY state sits between DATA and STOP and samples the parity bit at count CLK_CYCLES-1.
  - At STOP, a good stop bit with a parity mismatch gives o_parity_err=1 for one cycle, no o_valid, and o_data unchanged.
  - A framing error takes precedence over parity: only o_frame_err pulses.
  - Frame length becomes BIT_NUM+3 bits, and latency grows by CLK_CYCLES.
- Without the macro: no PARITY state, no port, no parameter; behaviour is exactly as above.

Test Plan:
1. Bench parameters CLK_CYCLES=16, BIT_NUM=8, line driven at 16 cycles/bit. Send 0xA5 -> exactly one o_valid pulse with o_data=0xA5, o_frame_err never high, o_busy high for the frame, valid at the latency formula (F+153).
2. Drive the line low for 4 cycles, then high -> FSM returns to IDLE after the half-bit check; no o_valid, no o_frame_err; o_data unchanged.
3. Send 0x3C with the stop bit forced 0, line held low for 40 cycles, then send 0x81 normally -> one o_frame_err pulse, o_data keeps its prior value, no spurious start during the low hold, then o_valid with o_data=0x81.
4. Send 0x00, 0xFF, 0x55 back-to-back with no idle gap -> three o_valid pulses 160 cycles apart carrying 0x00, 0xFF, 0x55.
5. Assert i_rst_n low during bit 3 of 0xC3, release, then send 0x12 -> outputs 0 during reset, no pulse for the aborted frame, o_valid with o_data=0x12.
6. With UART_RX_PARITY_EN and even parity: send 0x07 with parity bit 1 -> o_valid, o_data=0x07. Send 0x07 with parity bit 0 -> o_parity_err pulse only.
